rr_one_hot_arbiter: RTL and testbench
=====================================

// Module: rr_one_hot_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one downstream resource among NUM_REQ
//   requesters. It selects a winner, registers its binary index, and drives a
//   one-hot grant equal to 1 << grant_idx. A grant is held until the owner
//   finishes, withdraws its request, or hits a hold timeout. It sits between
//   requester agents and the shared datapath it controls.
//
// PARAMETERS
//   NUM_REQ   16  number of requesters; 2 <= NUM_REQ <= 2**IDX_W
//   IDX_W     4   width of grant_idx and of the round-robin pointer
//   MAX_HOLD  8   maximum cycles a single grant stays asserted; >= 1
//
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        asynchronous active-low reset
//   req         in   NUM_REQ  request vector, level-sensitive, 1 = wants resource
//   done        in   1        pulse from the current owner: transaction complete
//   grant       out  NUM_REQ  one-hot grant, all-zero when idle
//   grant_idx   out  IDX_W    binary index of the current owner
//   grant_valid out  1        1 = grant is active
//
// BEHAVIOUR
//   - Reset (async assert, sync deassert at the clk edge):
//     state=IDLE, grant=0, grant_idx=0, grant_valid=0, ptr=0, hold_cnt=0.
//     Reset asserted mid-grant drops all outputs immediately.
//   - All outputs are registered. Invariant:
//     grant == (grant_valid ? 1<<grant_idx : 0), so grant is always onehot0.
//   - FSM with two states, IDLE and BUSY.
//   - IDLE:
//     - If req != 0, the winner is the first set bit found by a circular
//       search that starts at ptr and wraps NUM_REQ-1 -> 0.
//     - At the next edge: grant_idx=winner, grant_valid=1, hold_cnt=0,
//       state=BUSY. Latency is req sampled at edge N, grant visible after edge N.
//     - done is ignored in IDLE.
//   - BUSY:
//     - Release occurs when any of these holds: done=1, req[grant_idx]=0,
//       or hold_cnt==MAX_HOLD-1.
//     - On release, at the next edge: grant=0, grant_valid=0, state=IDLE,
//       ptr=(grant_idx+1) mod NUM_REQ.
//     - Otherwise hold_cnt increments.
//     - Several release causes in the same cycle produce a single release.
//     - A grant therefore lasts between 1 and MAX_HOLD cycles.
//     - Requests from other requesters during BUSY do not pre-empt the owner.
//   - Exactly one IDLE cycle separates consecutive grants. This is a fixed
//     turnaround, even when the same requester wins again.
//   - Fairness: after any grant, ptr moves past the owner. With all requesters
//     active continuously, each is granted once per NUM_REQ grants.
//   - Widths:
//     - hold_cnt is $clog2(MAX_HOLD+1) bits.
//     - ptr wraps explicitly at NUM_REQ, not at 2**IDX_W.
//     - grant is computed by a shift of a 1 into NUM_REQ bits.
//
// TESTING  (NUM_REQ=16, IDX_W=4, MAX_HOLD=8 unless stated)
//   1 rst_n=0 with random req -> grant=0, grant_idx=0, grant_valid=0;
//     release reset with req=0 -> design stays idle for 10 cycles.
//   2 req=16'h0020 from edge 0; done pulse during cycle 3 ->
//     grant=16'h0020, idx=5, valid=1 after edge 1; grant=0 after edge 4;
//     ptr=6.
//   3 req=16'h4003 held; owner pulses done 1 cycle after each grant ->
//     grant order is idx 0,1,14,0,1, with one idle cycle between grants.
//   4 req=16'h0008 held, done=0 -> grant=16'h0008 for exactly 8 cycles,
//     then 1 idle cycle, then re-granted to idx 3.
//   5 owner idx 2 drops req[2] mid-grant -> grant clears at the next edge;
//     pending req[9] granted 1 cycle later.
//   6 rst_n pulsed low while idx 7 is granted -> grant=0 without a clock edge;
//     after reset with req=16'h0006 -> idx 1 granted (ptr restarted at 0).
//   All tests: assert the onehot0 invariant and grant==1<<grant_idx every cycle.

Source files
------------

// File: rtl/rr_one_hot_arbiter.sv
// Round-robin arbiter with a registered one-hot grant and binary owner index.
// A grant is held until done, request withdrawal, or the hold timeout.
module rr_one_hot_arbiter #(
  parameter int NUM_REQ  = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  localparam int HC_W = $clog2(MAX_HOLD + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]         state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic               valid_reg, valid_next;
  logic [NUM_REQ-1:0] grant_reg, grant_next;
  logic [HC_W-1:0]    hold_cnt_reg, hold_cnt_next;

  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;
  logic [IDX_W-1:0]   win_idx;
  logic               rel_cond;

  // cand[gi] is the requester visited gi steps after ptr, wrapping at NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum      = {1'b0, ptr_reg} + (IDX_W+1)'(gi);
      assign cand[gi] = (sum >= (IDX_W+1)'(NUM_REQ))
                        ? IDX_W'(sum - (IDX_W+1)'(NUM_REQ))
                        : sum[IDX_W-1:0];
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  // Scan from the far end so the closest hit to ptr is written last.
  always_comb begin
    win_idx = ptr_reg;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (hit[i]) win_idx = cand[i];
    end
  end

  assign rel_cond = done || !req[idx_reg] ||
                    (hold_cnt_reg == HC_W'(MAX_HOLD - 1));

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    idx_next      = idx_reg;
    valid_next    = valid_reg;
    grant_next    = grant_reg;
    hold_cnt_next = hold_cnt_reg;
    if (state_reg == IDLE) begin
      if (|req) begin
        state_next    = BUSY;
        idx_next      = win_idx;
        valid_next    = 1'b1;
        grant_next    = NUM_REQ'(1) << win_idx;
        hold_cnt_next = '0;
      end
    end else begin
      if (rel_cond) begin
        state_next = IDLE;
        valid_next = 1'b0;
        grant_next = '0;
        ptr_next   = (idx_reg == IDX_W'(NUM_REQ - 1)) ? '0 : idx_reg + IDX_W'(1);
      end else begin
        hold_cnt_next = hold_cnt_reg + HC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      idx_reg      <= '0;
      valid_reg    <= 1'b0;
      grant_reg    <= '0;
      hold_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      idx_reg      <= idx_next;
      valid_reg    <= valid_next;
      grant_reg    <= grant_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  assign grant       = grant_reg;
  assign grant_idx   = idx_reg;
  assign grant_valid = valid_reg;

endmodule

// File: tb/tb_rr_one_hot_arbiter.sv
// Directed bench for rr_one_hot_arbiter: expected outputs are queued when a
// step is driven and popped after the following clock edge.
module tb_rr_one_hot_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] grant;
    logic [3:0]  idx;
    logic        valid;
    logic        chk_idx;
  } exp_t;

  exp_t sb[$];

  rr_one_hot_arbiter #(.NUM_REQ(16), .IDX_W(4), .MAX_HOLD(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Invariants checked every cycle away from the active edge.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      checks++;
      assert (grant === (grant_valid ? (16'h1 << grant_idx) : 16'h0)) else begin
        errors++;
        $error("FAIL inv_shift: grant=%h valid=%b idx=%0d", grant, grant_valid, grant_idx);
      end
      checks++;
      assert ($onehot0(grant)) else begin
        errors++;
        $error("FAIL inv_onehot0: grant=%h", grant);
      end
    end
  end

  task automatic push_exp(input string tag, input logic [15:0] g, input logic [3:0] i,
                          input logic ci);
    exp_t e;
    e.tag = tag; e.grant = g; e.idx = i; e.valid = (g != 16'h0); e.chk_idx = ci;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL sb_empty: observed grant=%h with no expectation queued", grant);
      return;
    end
    e = sb.pop_front();
    $display("%0t %s req=%h done=%b grant=%h idx=%0d valid=%b", $time, e.tag, req, done,
             grant, grant_idx, grant_valid);
    checks++;
    assert (grant === e.grant) else begin
      errors++;
      $error("FAIL %s grant: got %h expected %h", e.tag, grant, e.grant);
    end
    checks++;
    assert (grant_valid === e.valid) else begin
      errors++;
      $error("FAIL %s valid: got %b expected %b", e.tag, grant_valid, e.valid);
    end
    if (e.chk_idx) begin
      checks++;
      assert (grant_idx === e.idx) else begin
        errors++;
        $error("FAIL %s idx: got %0d expected %0d", e.tag, grant_idx, e.idx);
      end
    end
  endtask

  // Drive inputs for the next edge, then compare the outputs after it.
  task automatic step(input logic [15:0] r, input logic d, input string tag,
                      input logic [15:0] g, input logic [3:0] i, input logic ci);
    req  = r;
    done = d;
    push_exp(tag, g, i, ci);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 16'h0;
    done  = 1'b0;
    push_exp("reset", 16'h0, 4'd0, 1'b1);
    @(posedge clk);
    #1;
    check_out();
    rst_n = 1'b1;
  endtask

  int order[5] = '{0, 1, 14, 0, 1};

  initial begin
    rst_n = 1'b0;
    req   = 16'h0;
    done  = 1'b0;

    // 1: reset with random requests, then idle with no requests
    for (int k = 0; k < 3; k++) step(16'($urandom), 1'b0, "t1_rst", 16'h0, 4'd0, 1'b1);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) step(16'h0, 1'b0, "t1_idle", 16'h0, 4'd0, 1'b1);

    // 2: single requester, done ends the grant; ptr then sits at 6
    step(16'h0020, 1'b0, "t2_grant", 16'h0020, 4'd5, 1'b1);
    step(16'h0020, 1'b0, "t2_hold", 16'h0020, 4'd5, 1'b1);
    step(16'h0020, 1'b0, "t2_hold", 16'h0020, 4'd5, 1'b1);
    step(16'h0020, 1'b1, "t2_done", 16'h0000, 4'd0, 1'b0);
    step(16'h0041, 1'b0, "t2_ptr6", 16'h0040, 4'd6, 1'b1);
    step(16'h0000, 1'b0, "t2_drop", 16'h0000, 4'd0, 1'b0);
    step(16'h0000, 1'b0, "t2_idle", 16'h0000, 4'd0, 1'b0);

    // 3: rotation among 0, 1, 14 with a one-cycle done response
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(16'h4003, 1'b0, "t3_grant", 16'h1 << order[k], 4'(order[k]), 1'b1);
      step(16'h4003, 1'b1, "t3_rel", 16'h0, 4'd0, 1'b0);
    end
    step(16'h0000, 1'b0, "t3_idle", 16'h0, 4'd0, 1'b0);

    // 4: hold timeout after 8 cycles, one idle cycle, then re-grant
    for (int k = 0; k < 8; k++) step(16'h0008, 1'b0, "t4_hold", 16'h0008, 4'd3, 1'b1);
    step(16'h0008, 1'b0, "t4_timeout", 16'h0, 4'd0, 1'b0);
    step(16'h0008, 1'b0, "t4_regrant", 16'h0008, 4'd3, 1'b1);
    step(16'h0000, 1'b0, "t4_drop", 16'h0, 4'd0, 1'b0);
    step(16'h0000, 1'b0, "t4_idle", 16'h0, 4'd0, 1'b0);

    // 5: owner withdraws, pending requester 9 follows after one idle cycle
    do_reset();
    step(16'h0204, 1'b0, "t5_grant", 16'h0004, 4'd2, 1'b1);
    step(16'h0204, 1'b0, "t5_hold", 16'h0004, 4'd2, 1'b1);
    step(16'h0200, 1'b0, "t5_withdraw", 16'h0, 4'd0, 1'b0);
    step(16'h0200, 1'b0, "t5_next", 16'h0200, 4'd9, 1'b1);
    step(16'h0000, 1'b0, "t5_drop", 16'h0, 4'd0, 1'b0);

    // 6: park ptr at 2, grant 7, reset mid-grant; ptr must restart at 0
    step(16'h0002, 1'b0, "t6_g1", 16'h0002, 4'd1, 1'b1);
    step(16'h0000, 1'b0, "t6_rel1", 16'h0, 4'd0, 1'b0);
    step(16'h0080, 1'b0, "t6_g7", 16'h0080, 4'd7, 1'b1);
    #3;
    rst_n = 1'b0;
    push_exp("t6_async_rst", 16'h0, 4'd0, 1'b1);
    #1;
    check_out();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(16'h0006, 1'b0, "t6_after_rst", 16'h0002, 4'd1, 1'b1);
    step(16'h0000, 1'b0, "t6_drop", 16'h0, 4'd0, 1'b0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
